// File: rtl/fd_pkg.sv
// Shared constants, state encoding and circle geometry for the FAST9 circle fetcher.
// The offset table lists the radius-3 Bresenham circle clockwise, starting directly above the reference.
package fd_pkg;

   localparam int COLUMNS    = 180;
   localparam int ROWS       = 120;
   localparam int AW         = 15;
   localparam int DW         = 8;
   localparam int BORDER     = 3;
   localparam int NUM_CIRCLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CENTER,
      ST_CIRCLE,
      ST_DRAIN,
      ST_DONE
   } state_e;

   localparam int signed CIRCLE_OFS [NUM_CIRCLE] = '{
      -3*COLUMNS,     -3*COLUMNS + 1, -2*COLUMNS + 2, -COLUMNS + 3,
      3,              COLUMNS + 3,    2*COLUMNS + 2,  3*COLUMNS + 1,
      3*COLUMNS,      3*COLUMNS - 1,  2*COLUMNS - 2,  COLUMNS - 3,
      -3,             -COLUMNS - 3,   -2*COLUMNS - 2, -3*COLUMNS - 1
   };

   localparam logic [6:0] ROW_MIN = 7'(BORDER);
   localparam logic [6:0] ROW_MAX = 7'(ROWS - 1 - BORDER);
   localparam logic [7:0] COL_MIN = 8'(BORDER);
   localparam logic [7:0] COL_MAX = 8'(COLUMNS - 1 - BORDER);

   // Any row/col whose circle would leave the image, including out-of-range values.
   function automatic logic is_border(input logic [6:0] row, input logic [7:0] col);
      return (row < ROW_MIN) || (row > ROW_MAX) || (col < COL_MIN) || (col > COL_MAX);
   endfunction

   function automatic logic [AW-1:0] lin_addr(input logic [6:0] row, input logic [7:0] col);
      return AW'(row) * AW'(COLUMNS) + AW'(col);
   endfunction

endpackage

// File: rtl/fd_circle_addr.sv
// Combinational circle address generator: reference address plus the table offset of one circle position.
// Arithmetic wraps modulo 2^AW, which only matters for border references that never read.
module fd_circle_addr
   import fd_pkg::*;
(
   input  logic [AW-1:0] ref_addr_i,
   input  logic [3:0]    idx_i,
   output logic [AW-1:0] addr_o
);

   logic [AW-1:0] ofs;

   always_comb begin
      ofs    = AW'(CIRCLE_OFS[idx_i]);
      addr_o = ref_addr_i + ofs;
   end

endmodule

// File: rtl/fd_circle_fetch_ctrl.sv
// Fetches the centre pixel and the 16 FAST9 circle pixels around a reference and hands them
// downstream as one packed result under a valid/ack handshake.
module fd_circle_fetch_ctrl
   import fd_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [6:0]               ref_row,
   input  logic [7:0]               ref_col,
   output logic                     busy,
   output logic                     sram_re,
   output logic [AW-1:0]            sram_addr,
   input  logic [DW-1:0]            sram_rdata,
   output logic                     result_valid,
   output logic                     result_border,
   output logic [AW-1:0]            result_addr,
   output logic [DW-1:0]            center_pix,
   output logic [NUM_CIRCLE*DW-1:0] circle_pix,
   input  logic                     result_ack
);

   state_e        state_q;
   logic [3:0]    idx_q;
   logic [AW-1:0] ref_addr_q;
   logic          busy_q;
   logic          sram_re_q;
   logic [AW-1:0] sram_addr_q;
   logic [4:0]    slot_q;
   logic          pend_q;
   logic [4:0]    pend_slot_q;
   logic          result_valid_q;
   logic          result_border_q;
   logic [DW-1:0] center_q;
   logic [DW-1:0] circle_q [NUM_CIRCLE];

   logic [AW-1:0] ref_addr_d;
   logic          border_d;
   logic [3:0]    circ_idx_d;
   logic [AW-1:0] circ_addr_d;

   always_comb begin
      ref_addr_d = lin_addr(ref_row, ref_col);
      border_d   = is_border(ref_row, ref_col);
      circ_idx_d = (state_q == ST_CENTER) ? 4'd0 : idx_q + 4'd1;
   end

   // Address for the read issued in the following cycle.
   fd_circle_addr u_circle_addr (
      .ref_addr_i (ref_addr_q),
      .idx_i      (circ_idx_d),
      .addr_o     (circ_addr_d)
   );

   // slot_q tags each read (0 = centre, 1..16 = circle); pend_* delays it to the data cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ST_IDLE;
         idx_q           <= '0;
         ref_addr_q      <= '0;
         busy_q          <= 1'b0;
         sram_re_q       <= 1'b0;
         sram_addr_q     <= '0;
         slot_q          <= '0;
         pend_q          <= 1'b0;
         pend_slot_q     <= '0;
         result_valid_q  <= 1'b0;
         result_border_q <= 1'b0;
      end else begin
         pend_q      <= sram_re_q;
         pend_slot_q <= slot_q;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  ref_addr_q <= ref_addr_d;
                  busy_q     <= 1'b1;
                  if (border_d) begin
                     state_q         <= ST_DONE;
                     result_valid_q  <= 1'b1;
                     result_border_q <= 1'b1;
                  end else begin
                     state_q         <= ST_CENTER;
                     result_border_q <= 1'b0;
                     sram_re_q       <= 1'b1;
                     sram_addr_q     <= ref_addr_d;
                     slot_q          <= 5'd0;
                  end
               end
            end
            ST_CENTER: begin
               state_q     <= ST_CIRCLE;
               idx_q       <= 4'd0;
               sram_addr_q <= circ_addr_d;
               slot_q      <= 5'd1;
            end
            ST_CIRCLE: begin
               if (idx_q == 4'(NUM_CIRCLE - 1)) begin
                  state_q     <= ST_DRAIN;
                  idx_q       <= 4'd0;
                  sram_re_q   <= 1'b0;
                  sram_addr_q <= '0;
                  slot_q      <= 5'd0;
               end else begin
                  idx_q       <= idx_q + 4'd1;
                  sram_addr_q <= circ_addr_d;
                  slot_q      <= slot_q + 5'd1;
               end
            end
            ST_DRAIN: begin
               state_q        <= ST_DONE;
               result_valid_q <= 1'b1;
            end
            ST_DONE: begin
               if (result_ack) begin
                  state_q        <= ST_IDLE;
                  result_valid_q <= 1'b0;
                  busy_q         <= 1'b0;
               end
            end
            default: begin
               state_q        <= ST_IDLE;
               busy_q         <= 1'b0;
               sram_re_q      <= 1'b0;
               sram_addr_q    <= '0;
               result_valid_q <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         center_q <= '0;
         for (int i = 0; i < NUM_CIRCLE; i++) begin
            circle_q[i] <= '0;
         end
      end else if (pend_q) begin
         if (pend_slot_q == 5'd0) begin
            center_q <= sram_rdata;
         end
         for (int i = 0; i < NUM_CIRCLE; i++) begin
            if (pend_slot_q == 5'(i + 1)) begin
               circle_q[i] <= sram_rdata;
            end
         end
      end
   end

   for (genvar gi = 0; gi < NUM_CIRCLE; gi++) begin : g_pack
      assign circle_pix[DW*gi +: DW] = circle_q[gi];
   end

   assign busy          = busy_q;
   assign sram_re       = sram_re_q;
   assign sram_addr     = sram_addr_q;
   assign result_valid  = result_valid_q;
   assign result_border = result_border_q;
   assign result_addr   = ref_addr_q;
   assign center_pix    = center_q;

endmodule

// File: tb/tb_fd_circle_fetch_ctrl.sv
// Directed bench for fd_circle_fetch_ctrl: SRAM model returns addr[7:0] one cycle after each read.
module tb_fd_circle_fetch_ctrl;
   import fd_pkg::*;

   logic                     clk = 1'b0;
   logic                     reset_n = 1'b0;
   logic                     start = 1'b0;
   logic [6:0]               ref_row = '0;
   logic [7:0]               ref_col = '0;
   logic                     busy;
   logic                     sram_re;
   logic [AW-1:0]            sram_addr;
   logic [DW-1:0]            sram_rdata = '0;
   logic                     result_valid;
   logic                     result_border;
   logic [AW-1:0]            result_addr;
   logic [DW-1:0]            center_pix;
   logic [NUM_CIRCLE*DW-1:0] circle_pix;
   logic                     result_ack = 1'b0;

   int nvec = 0;
   int nerr = 0;
   int cyc = 0;
   int rd_total = 0;
   int viol = 0;
   int last_rise = 0;
   logic valid_prev = 1'b0;
   logic [AW-1:0] rd_addr [17];

   fd_circle_fetch_ctrl dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .ref_row       (ref_row),
      .ref_col       (ref_col),
      .busy          (busy),
      .sram_re       (sram_re),
      .sram_addr     (sram_addr),
      .sram_rdata    (sram_rdata),
      .result_valid  (result_valid),
      .result_border (result_border),
      .result_addr   (result_addr),
      .center_pix    (center_pix),
      .circle_pix    (circle_pix),
      .result_ack    (result_ack)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      sram_rdata <= sram_re ? sram_addr[7:0] : 8'hEE;
   end

   always @(negedge clk) begin
      if (sram_re) rd_total <= rd_total + 1;
      if ((sram_re && (result_valid || !busy)) || (!sram_re && sram_addr != '0)) viol <= viol + 1;
      if (result_valid && !valid_prev) last_rise <= cyc;
      valid_prev <= result_valid;
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Accepts one request and runs until result_valid (bounded); reads logged into rd_addr.
   task automatic fetch(input logic [6:0] r, input logic [7:0] c,
                        output int nrd, output int vrel, output int first_rd, output int last_rd);
      @(negedge clk);
      ref_row = r; ref_col = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nrd = 0; vrel = -1; first_rd = -1; last_rd = -1;
      for (int rel = 1; rel <= 40; rel++) begin
         if (sram_re) begin
            if (nrd < 17) rd_addr[nrd] = sram_addr;
            nrd++;
            if (first_rd < 0) first_rd = rel;
            last_rd = rel;
         end
         if (result_valid) begin
            vrel = rel;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic ack(input logic with_start);
      @(negedge clk);
      result_ack = 1'b1; start = with_start; ref_row = 7'd20; ref_col = 8'd20;
      @(negedge clk);
      result_ack = 1'b0; start = 1'b0;
   endtask

   int nrd, vrel, frd, lrd, rd0, t1, t2;

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_re", sram_re, 0);
      chk("rst_addr", result_addr, 0);
      chk("rst_circle", circle_pix, 0);
      reset_n = 1'b1;

      // Reset asserted in the middle of the circle reads
      @(negedge clk);
      ref_row = 7'd10; ref_col = 8'd10; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid_re_before", sram_re, 1);
      reset_n = 1'b0;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_re", sram_re, 0);
      chk("mid_sram_addr", sram_addr, 0);
      chk("mid_center", center_pix, 0);
      chk("mid_circle", circle_pix, 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_no_result", result_valid, 0);
      fetch(7'd10, 8'd10, nrd, vrel, frd, lrd);
      chk("r10_vrel", vrel, 19);
      chk("r10_nrd", nrd, 17);
      chk("r10_addr", result_addr, 1810);
      chk("r10_center", center_pix, 8'h12);
      chk("r10_c0", circle_pix[7:0], 8'hF6);
      ack(1'b0);

      // Interior (3,3) plus handshake hold
      fetch(7'd3, 8'd3, nrd, vrel, frd, lrd);
      chk("i33_vrel", vrel, 19);
      chk("i33_nrd", nrd, 17);
      chk("i33_first_rd", frd, 1);
      chk("i33_last_rd", lrd, 17);
      chk("i33_rd_center", rd_addr[0], 543);
      chk("i33_rd_c0", rd_addr[1], 3);
      chk("i33_rd_c4", rd_addr[5], 546);
      chk("i33_rd_c8", rd_addr[9], 1083);
      chk("i33_rd_c15", rd_addr[16], 2);
      chk("i33_addr", result_addr, 543);
      chk("i33_border", result_border, 0);
      chk("i33_center", center_pix, 8'h1F);
      chk("i33_c0", circle_pix[7:0], 8'h03);
      chk("i33_c4", circle_pix[39:32], 8'h22);
      chk("i33_c8", circle_pix[71:64], 8'h3B);
      chk("i33_c15", circle_pix[127:120], 8'h02);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         start = (k == 2); ref_row = 7'd10; ref_col = 8'd10;
         chk("hold_valid", result_valid, 1);
         chk("hold_addr", result_addr, 543);
         chk("hold_c8", circle_pix[71:64], 8'h3B);
      end
      start = 1'b0;
      ack(1'b1);
      chk("ack_valid_low", result_valid, 0);
      chk("ack_start_ignored", busy, 0);

      // Corner-most interior reference
      fetch(7'd116, 8'd176, nrd, vrel, frd, lrd);
      chk("cor_nrd", nrd, 17);
      chk("cor_addr", result_addr, 21056);
      chk("cor_border", result_border, 0);
      chk("cor_rd_c7", rd_addr[8], 21597);
      chk("cor_center", center_pix, 8'h40);
      chk("cor_c7", circle_pix[63:56], 8'h5D);
      ack(1'b0);

      // Border references
      fetch(7'd2, 8'd50, nrd, vrel, frd, lrd);
      chk("b1_vrel", vrel, 1);
      chk("b1_nrd", nrd, 0);
      chk("b1_border", result_border, 1);
      chk("b1_addr", result_addr, 410);
      chk("b1_center_kept", center_pix, 8'h40);
      ack(1'b0);
      fetch(7'd60, 8'd177, nrd, vrel, frd, lrd);
      chk("b2_vrel", vrel, 1);
      chk("b2_nrd", nrd, 0);
      chk("b2_border", result_border, 1);
      ack(1'b0);

      // Back-to-back: consumer acks the cycle after seeing valid, next start held high
      rd0 = rd_total;
      fetch(7'd50, 8'd60, nrd, vrel, frd, lrd);
      #1 t1 = last_rise;
      @(negedge clk);
      result_ack = 1'b1; start = 1'b1; ref_row = 7'd100; ref_col = 8'd100;
      @(negedge clk);
      result_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      vrel = -1;
      for (int k = 0; k < 40; k++) begin
         if (result_valid) begin
            vrel = k;
            break;
         end
         @(negedge clk);
      end
      #1;
      t2 = last_rise;
      chk("b2b_valid_seen", (vrel >= 0), 1);
      chk("b2b_gap", t2 - t1, 21);
      chk("b2b_reads", rd_total - rd0, 34);
      chk("b2b_addr", result_addr, 18100);
      ack(1'b0);
      #1;
      chk("re_protocol", viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/fd_circle_fetch_ctrl.md
Name: fd_circle_fetch_ctrl

Overview:
Sequencer that fetches one FAST9 Bresenham circle, radius 3, from the 180x120 8-bit image SRAM.
- Takes a reference pixel as (row, col) and checks the border.
- Issues 17 single-cycle SRAM reads: the centre, then circle positions 0..15 in order.
- Collects the returned bytes and presents one packed result to the downstream corner-score stage with a valid/ack handshake.
- Sits between the pixel-scan controller and the SRAM read port.

Parameters:
COLUMNS, 180, image width in pixels
ROWS, 120, image height in pixels
AW, 15, SRAM address width
DW, 8, pixel data width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  request to fetch the circle around (ref_row, ref_col); sampled only in IDLE
ref_row  in  7  reference row
ref_col  in  8  reference column
busy  out  1  high in every state except IDLE
sram_re  out  1  SRAM read enable, one read per asserted cycle
sram_addr  out  AW  SRAM read address
sram_rdata  in  DW  read data, valid exactly 1 cycle after sram_re
result_valid  out  1  result held stable until acknowledged
result_border  out  1  reference too close to the edge; pixel fields not updated
result_addr  out  AW  linear reference address, row*COLUMNS+col
center_pix  out  DW  centre pixel
circle_pix  out  16*DW  circle pixel i at bits [DW*i+DW-1 : DW*i]
result_ack  in  1  consumer acknowledge

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0. Reset is asynchronous and takes effect mid-operation; no partial result is ever presented afterwards.
- Address: ref_addr = ref_row*COLUMNS + ref_col, computed with a constant multiply and kept in AW bits; latched on start acceptance.
- Circle offsets for positions 0..15, with C = COLUMNS:
  -3C, -3C+1, -2C+2, -C+3, +3, +C+3, +2C+2, +3C+1, +3C, +3C-1, +2C-2, +C-3, -3, -C-3, -2C-2, -3C-1.
- Address arithmetic is modulo 2^AW. Wrap cannot occur for non-border references.
- Border rule: the reference is a border reference if row<3, row>ROWS-4, col<3 or col>COLUMNS-4. Out-of-range row/col values are treated the same way.
- States:
  - IDLE: start=1 latches the inputs. Border reference -> DONE with result_border=1, no SRAM access. Otherwise -> CENTER.
  - CENTER: sram_re=1, sram_addr=ref_addr -> CIRCLE with idx=0.
  - CIRCLE: sram_re=1, sram_addr=ref_addr+offset[idx], idx increments each cycle; after idx=15 -> DRAIN.
  - DRAIN: captures the last byte (circle 15) -> DONE.
  - DONE: result_valid=1, outputs frozen; result_ack=1 -> IDLE.
- Capture: on the cycle after each read, sram_rdata is written to the slot of that read (centre, then circle 0..15). This is tracked with a 1-cycle-delayed slot index.
- Timing for an interior reference, start accepted at cycle 0:
  - reads issued at cycles 1..17;
  - data captured at cycles 2..18;
  - result_valid high from cycle 19.
  Border reference: result_valid high from cycle 1.
- result_valid deasserts the cycle after the ack. result_border=0 for interior results.
- start while busy is ignored, including start in the same cycle as result_ack. The earliest new acceptance is the cycle after the return to IDLE.
- result_ack outside DONE is ignored.
- sram_re is never high in IDLE, DRAIN or DONE. sram_addr is 0 whenever sram_re=0.

Decomposition:
- Package fd_pkg:
  - COLUMNS, ROWS, AW, DW, BORDER=3, NUM_CIRCLE=16;
  - the state enum;
  - the signed offset table constant.
- Sub-module fd_circle_addr: purely combinational; (ref_addr, idx) -> circle address from the fd_pkg offset table.
- The controller contains the FSM, counters, capture registers and border check.

Test Plan:
- Reset mid-CIRCLE (assert reset_n=0 at cycle 8) -> all outputs 0 immediately; later start at (10,10) runs cleanly with correct timing.
- Interior start row=3, col=3 -> result_addr=543; reads at 543, then circle 0 = 3, circle 4 = 546, circle 8 = 1083, circle 15 = 2. With the SRAM model returning addr[7:0], center_pix=0x1F, circle_pix[7:0]=0x03, result_valid at cycle 19.
- Corner extreme row=116, col=176 -> ref 21056; circle 7 address 21597; result_border=0; 17 reads total.
- Border row=2, col=50 and row=60, col=177 -> result_valid at cycle 1, result_border=1, zero sram_re pulses.
- Handshake: hold result_ack=0 for 5 cycles -> outputs stable; start pulsed during DONE and in the ack cycle is ignored; start after returning to IDLE is accepted.
- Back-to-back: two interior requests with the ack given immediately -> exactly 34 reads, no overlap, second result_valid 21 cycles after the first.
